// File: rtl/pilot_insert_pkg.sv
// Shared constants and carrier-map helpers for the pilot inserter.
// No ports: imported by pilot_insert and pilot_pn_gen.
package pilot_insert_pkg;

  localparam int N_DATA = 48;
  localparam int N_FFT  = 64;

  localparam logic [5:0] PILOT_K0 = 6'd7;
  localparam logic [5:0] PILOT_K1 = 6'd21;  // the one pilot carried inverted
  localparam logic [5:0] PILOT_K2 = 6'd43;
  localparam logic [5:0] PILOT_K3 = 6'd57;

  localparam logic [15:0] PILOT_POS = 16'h2000;
  localparam logic [15:0] PILOT_NEG = 16'hE000;

  localparam logic [6:0] LFSR_SEED = 7'h7F;
  localparam logic [6:0] N_LAST    = 7'd126;  // polarity index wraps here

  typedef enum logic [1:0] {K_NULL, K_PILOT, K_PILOT_INV, K_DATA} kind_t;

  // Logical data index (carriers -26..26 minus 0, +-7, +-21) to IFFT bin.
  function automatic logic [5:0] data_to_k(input logic [5:0] i);
    if (i < 6'd5)       return i + 6'd38;
    else if (i < 6'd18) return i + 6'd39;
    else if (i < 6'd24) return i + 6'd40;
    else if (i < 6'd30) return i - 6'd23;
    else if (i < 6'd43) return i - 6'd22;
    else                return i - 6'd21;
  endfunction

  // Inverse map; bins that carry no data fall back to 0 (never read).
  function automatic logic [5:0] k_to_data(input logic [5:0] k);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < N_DATA; i++)
      if (data_to_k(6'(i)) == k) r = 6'(i);
    return r;
  endfunction

  function automatic kind_t k_kind(input logic [5:0] k);
    if (k == 6'd0 || (k >= 6'd27 && k <= 6'd37))           return K_NULL;
    if (k == PILOT_K0 || k == PILOT_K2 || k == PILOT_K3)  return K_PILOT;
    if (k == PILOT_K1)                                    return K_PILOT_INV;
    return K_DATA;
  endfunction

endpackage

// File: rtl/pilot_pn_gen.sv
// Pilot polarity generator: x^7+x^4+1 LFSR, seeded all-ones.
//   clk, rst  : clock, synchronous active-high reset (reseeds)
//   advance   : step to the next symbol's polarity
//   restart   : reseed (wins over advance)
//   pol       : 0 -> pilots +1, 1 -> pilots -1
module pilot_pn_gen
  import pilot_insert_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic restart,
  output logic pol
);

  logic [6:0] lfsr;

  // Bit 6 is the sample 7 steps back, bit 3 the one 4 steps back.
  assign pol = lfsr[6] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (rst || restart) lfsr <= LFSR_SEED;
    else if (advance)   lfsr <= {lfsr[5:0], pol};
  end

endmodule

// File: rtl/pilot_insert.sv
// Pilot inserter: collects 48 data subcarriers per symbol into ping-pong
// banks and emits 64 words in IFFT order with nulls and polarity pilots.
//   CLK_I, RST_I            : clock, synchronous active-high reset
//   DAT_I/WE_I/STB_I/CYC_I  : input words ({Im,Re} Q3.13), ACK_O accept
//   DAT_O/STB_O/CYC_O/WE_O  : output words, ACK_I downstream accept
module pilot_insert
  import pilot_insert_pkg::*;
(
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  logic [31:0] bank [2][N_DATA];
  logic [1:0]  full, full_nx;
  logic        wr_bank, rd_bank, out_bank;
  logic [5:0]  wr_cnt, wr_idx, rd_k;
  logic        rd_act, out_last, cyc_q;
  logic [6:0]  n;
  logic        pol;
  logic [31:0] word;
  logic        valid, in_halt, out_halt, pkt_start, last_wr, sym_done, n_wrap;

  assign valid     = WE_I & STB_I & CYC_I;
  assign in_halt   = &full;
  assign ACK_O     = valid & ~in_halt;
  assign pkt_start = CYC_I & ~cyc_q;
  assign wr_idx    = pkt_start ? 6'd0 : wr_cnt;
  assign last_wr   = ACK_O & (wr_idx == 6'(N_DATA - 1));
  assign out_halt  = STB_O & ~ACK_I;
  assign sym_done  = STB_O & ACK_I & out_last;
  assign n_wrap    = (n == N_LAST);
  assign WE_O      = CYC_O;

  pilot_pn_gen u_pn (
    .clk     (CLK_I),
    .rst     (RST_I),
    .advance (sym_done & ~n_wrap),
    .restart (pkt_start | (sym_done & n_wrap)),
    .pol     (pol)
  );

  // Data store; contents need no reset, the full flags gate all reads.
  always_ff @(posedge CLK_I) begin
    if (ACK_O) bank[wr_bank][wr_idx] <= DAT_I;
  end

  // Writer. Dropping CYC_I forgets any partial symbol; the bank is reused.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      cyc_q   <= 1'b1;
    end else begin
      cyc_q <= CYC_I;
      if (!CYC_I) wr_cnt <= '0;
      else if (ACK_O) begin
        if (last_wr) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_idx + 6'd1;
        end
      end else if (pkt_start) wr_cnt <= '0;
    end
  end

  // Free and fill always hit different banks, so both apply on one edge.
  always_comb begin
    full_nx = full;
    if (sym_done) full_nx[out_bank] = 1'b0;
    if (last_wr)  full_nx[wr_bank]  = 1'b1;
  end

  always_comb begin
    word = '0;
    case (k_kind(rd_k))
      K_PILOT:     word = {16'h0, pol ? PILOT_NEG : PILOT_POS};
      K_PILOT_INV: word = {16'h0, pol ? PILOT_POS : PILOT_NEG};
      K_DATA:      word = bank[rd_bank][k_to_data(rd_k)];
      default:     word = '0;
    endcase
  end

  // Reader feeds the output register; a stalled output freezes everything.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      full     <= '0;
      rd_act   <= 1'b0;
      rd_k     <= '0;
      rd_bank  <= 1'b0;
      out_bank <= 1'b0;
      out_last <= 1'b0;
      STB_O    <= 1'b0;
      DAT_O    <= '0;
      CYC_O    <= 1'b0;
      n        <= '0;
    end else begin
      full <= full_nx;
      if (!out_halt) begin
        STB_O <= rd_act;
        if (rd_act) begin
          DAT_O    <= word;
          out_last <= (rd_k == 6'(N_FFT - 1));
          out_bank <= rd_bank;
          CYC_O    <= 1'b1;
          rd_k     <= rd_k + 6'd1;
          // Chain straight into the other bank when it is already waiting.
          if (rd_k == 6'(N_FFT - 1)) begin
            rd_bank <= ~rd_bank;
            rd_act  <= full[~rd_bank];
          end
        end
      end
      if (!rd_act && full[rd_bank]) rd_act <= 1'b1;
      if (CYC_O && !STB_O && !rd_act && !CYC_I && full == 2'b00) CYC_O <= 1'b0;
      if (pkt_start)     n <= '0;
      else if (sym_done) n <= n_wrap ? 7'd0 : n + 7'd1;
    end
  end

endmodule

// File: tb/tb_pilot_insert.sv
// Directed bench for pilot_insert: one task per scenario, inline checks.
module tb_pilot_insert;

  logic        CLK_I = 1'b0;
  logic        RST_I, WE_I, STB_I, CYC_I, ACK_I;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_I, DAT_O;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;
  logic [31:0] out_q[$];
  int          stamp_q[$];
  int          idx_of_car[53];
  bit          pn[127];

  pilot_insert dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Record every accepted output word and the cycle it was seen.
  always @(negedge CLK_I) begin
    cyc_n++;
    if (!RST_I && STB_O && ACK_I) begin
      out_q.push_back(DAT_O);
      stamp_q.push_back(cyc_n);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference word for bin k of a symbol whose data words are {tag, i}.
  function automatic logic [31:0] exp_word(input int tag, input int k, input bit pol);
    int c;
    c = (k < 32) ? k : k - 64;
    if (k == 0 || (k >= 27 && k <= 37)) return 32'h0;
    if (k == 7 || k == 43 || k == 57)   return pol ? 32'h0000E000 : 32'h00002000;
    if (k == 21)                        return pol ? 32'h00002000 : 32'h0000E000;
    return {16'(tag), 16'(idx_of_car[c + 26])};
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push_sym(input int tag, input int nw);
    for (int i = 0; i < nw; i++) begin
      int t;
      t = 0;
      DAT_I = {16'(tag), 16'(i)};
      WE_I = 1'b1;
      STB_I = 1'b1;
      @(negedge CLK_I);
      while (!ACK_O && t < 2000) begin
        @(negedge CLK_I);
        t++;
      end
      if (!ACK_O) begin
        n_cmp++; n_bad++;
        $display("FAIL push_timeout tag=%0d word=%0d", tag, i);
      end
      tick();
    end
    WE_I = 1'b0;
    STB_I = 1'b0;
  endtask

  task automatic wait_words(input int nw, input int budget, input string nm);
    int t;
    t = 0;
    while (out_q.size() < nw && t < budget) begin
      tick();
      t++;
    end
    repeat (8) tick();
    n_cmp++;
    if (out_q.size() != nw) begin
      n_bad++;
      $display("FAIL %s_count got=%0d want=%0d", nm, out_q.size(), nw);
    end
  endtask

  task automatic start_pkt();
    out_q.delete();
    stamp_q.delete();
    CYC_I = 1'b0;
    tick();
    CYC_I = 1'b1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1; WE_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0; ACK_I = 1'b1; DAT_I = '0;
    repeat (3) tick();
    @(negedge CLK_I);
    n_cmp += 5;
    if (STB_O !== 1'b0)  begin n_bad++; $display("FAIL rst_stb got=%b want=0", STB_O); end
    if (CYC_O !== 1'b0)  begin n_bad++; $display("FAIL rst_cyc got=%b want=0", CYC_O); end
    if (WE_O !== 1'b0)   begin n_bad++; $display("FAIL rst_we got=%b want=0", WE_O); end
    if (DAT_O !== 32'h0) begin n_bad++; $display("FAIL rst_dat got=%h want=0", DAT_O); end
    if (ACK_O !== 1'b0)  begin n_bad++; $display("FAIL rst_ack got=%b want=0", ACK_O); end
    tick();
    RST_I = 1'b0;
    tick();
  endtask

  task automatic test_one_symbol();
    int gaps;
    logic [31:0] e;
    start_pkt();
    push_sym(0, 48);
    // d47 was taken on the edge just passed; STB_O must rise two edges later.
    @(negedge CLK_I);
    n_cmp++;
    if (STB_O !== 1'b0) begin n_bad++; $display("FAIL one_stb_e0 got=%b want=0", STB_O); end
    tick();
    @(negedge CLK_I);
    n_cmp++;
    if (STB_O !== 1'b0) begin n_bad++; $display("FAIL one_stb_e1 got=%b want=0", STB_O); end
    tick();
    @(negedge CLK_I);
    n_cmp += 2;
    if (STB_O !== 1'b1) begin n_bad++; $display("FAIL one_stb_e2 got=%b want=1", STB_O); end
    if (CYC_O !== 1'b1) begin n_bad++; $display("FAIL one_cyc_rise got=%b want=1", CYC_O); end
    tick();
    CYC_I = 1'b0;
    wait_words(64, 300, "one");
    gaps = 0;
    for (int i = 1; i < stamp_q.size(); i++) if (stamp_q[i] != stamp_q[i-1] + 1) gaps++;
    n_cmp++;
    if (gaps != 0) begin n_bad++; $display("FAIL one_gaps got=%0d want=0", gaps); end
    for (int k = 0; k < 64; k++) begin
      e = exp_word(0, k, pn[0]);
      n_cmp++;
      if (out_q[k] !== e) begin n_bad++; $display("FAIL one_word k=%0d got=%h want=%h", k, out_q[k], e); end
    end
    n_cmp += 6;
    if (out_q[1]  !== 32'd24)       begin n_bad++; $display("FAIL one_k1 got=%h want=18", out_q[1]); end
    if (out_q[38] !== 32'd0)        begin n_bad++; $display("FAIL one_k38 got=%h want=0", out_q[38]); end
    if (out_q[7]  !== 32'h00002000) begin n_bad++; $display("FAIL one_k7 got=%h want=2000", out_q[7]); end
    if (out_q[21] !== 32'h0000E000) begin n_bad++; $display("FAIL one_k21 got=%h want=e000", out_q[21]); end
    if (out_q[43] !== 32'h00002000) begin n_bad++; $display("FAIL one_k43 got=%h want=2000", out_q[43]); end
    if (out_q[57] !== 32'h00002000) begin n_bad++; $display("FAIL one_k57 got=%h want=2000", out_q[57]); end
    @(negedge CLK_I);
    n_cmp++;
    if (CYC_O !== 1'b0) begin n_bad++; $display("FAIL one_cyc_fall got=%b want=0", CYC_O); end
    tick();
  endtask

  task automatic test_back_to_back();
    int gaps;
    logic [31:0] e;
    logic [31:0] p7 [5];
    p7[0] = 32'h2000; p7[1] = 32'h2000; p7[2] = 32'h2000; p7[3] = 32'h2000; p7[4] = 32'hE000;
    start_pkt();
    for (int s = 0; s < 5; s++) push_sym(1 + s, 48);
    CYC_I = 1'b0;
    wait_words(320, 1000, "b2b");
    gaps = 0;
    for (int i = 1; i < stamp_q.size(); i++) if (stamp_q[i] != stamp_q[i-1] + 1) gaps++;
    n_cmp++;
    if (gaps != 0) begin n_bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if (out_q[s*64 + 7] !== p7[s])
        begin n_bad++; $display("FAIL b2b_pilot7 sym=%0d got=%h want=%h", s, out_q[s*64+7], p7[s]); end
      for (int k = 0; k < 64; k++) begin
        e = exp_word(1 + s, k, pn[s]);
        n_cmp++;
        if (out_q[s*64 + k] !== e)
          begin n_bad++; $display("FAIL b2b_word sym=%0d k=%0d got=%h want=%h", s, k, out_q[s*64+k], e); end
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] e;
    start_pkt();
    push_sym(40, 30);
    CYC_I = 1'b0;
    repeat (2) tick();
    CYC_I = 1'b1;
    push_sym(41, 48);
    CYC_I = 1'b0;
    wait_words(64, 300, "partial");
    n_cmp++;
    if (out_q[7] !== 32'h00002000) begin n_bad++; $display("FAIL partial_p0 got=%h want=2000", out_q[7]); end
    for (int k = 0; k < 64; k++) begin
      e = exp_word(41, k, pn[0]);
      n_cmp++;
      if (out_q[k] !== e) begin n_bad++; $display("FAIL partial_word k=%0d got=%h want=%h", k, out_q[k], e); end
    end
  endtask

  task automatic test_stall();
    int halt_cnt;
    logic [31:0] e;
    halt_cnt = 0;
    start_pkt();
    fork
      begin
        for (int s = 0; s < 3; s++) push_sym(10 + s, 48);
        CYC_I = 1'b0;
      end
      begin
        int t;
        logic [31:0] w20;
        t = 0;
        w20 = exp_word(10, 20, pn[0]);
        while (!(STB_O === 1'b1 && DAT_O === w20) && t < 1000) begin
          tick();
          t++;
        end
        n_cmp++;
        if (t >= 1000) begin n_bad++; $display("FAIL stall_trigger got=timeout want=k20"); end
        else begin
          ACK_I = 1'b0;
          repeat (5) begin
            @(negedge CLK_I);
            n_cmp += 2;
            if (DAT_O !== w20) begin n_bad++; $display("FAIL stall_dat got=%h want=%h", DAT_O, w20); end
            if (STB_O !== 1'b1) begin n_bad++; $display("FAIL stall_stb got=%b want=1", STB_O); end
            tick();
          end
          ACK_I = 1'b1;
        end
      end
      begin
        repeat (600) begin
          @(negedge CLK_I);
          if (WE_I && STB_I && CYC_I && !ACK_O) halt_cnt++;
        end
      end
    join
    wait_words(192, 1000, "stall");
    n_cmp++;
    if (!(halt_cnt > 0)) begin n_bad++; $display("FAIL stall_ack_halt got=%0d cycles want>0", halt_cnt); end
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 64; k++) begin
        e = exp_word(10 + s, k, pn[s]);
        n_cmp++;
        if (out_q[s*64 + k] !== e)
          begin n_bad++; $display("FAIL stall_word sym=%0d k=%0d got=%h want=%h", s, k, out_q[s*64+k], e); end
      end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    start_pkt();
    for (int s = 0; s < 128; s++) push_sym(s, 48);
    CYC_I = 1'b0;
    wait_words(128 * 64, 20000, "wrap");
    n_cmp++;
    if (out_q[127*64 + 7] !== 32'h00002000)
      begin n_bad++; $display("FAIL wrap_sym127 got=%h want=2000", out_q[127*64+7]); end
    for (int s = 0; s < 128; s++) begin
      e = exp_word(s, 7, pn[s % 127]);
      n_cmp += 4;
      if (out_q[s*64 + 7] !== e)  begin n_bad++; $display("FAIL wrap_k7 sym=%0d got=%h want=%h", s, out_q[s*64+7], e); end
      if (out_q[s*64 + 43] !== e) begin n_bad++; $display("FAIL wrap_k43 sym=%0d got=%h want=%h", s, out_q[s*64+43], e); end
      e = exp_word(s, 21, pn[s % 127]);
      if (out_q[s*64 + 21] !== e) begin n_bad++; $display("FAIL wrap_k21 sym=%0d got=%h want=%h", s, out_q[s*64+21], e); end
      e = exp_word(s, 1, pn[s % 127]);
      if (out_q[s*64 + 1] !== e)  begin n_bad++; $display("FAIL wrap_k1 sym=%0d got=%h want=%h", s, out_q[s*64+1], e); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [31:0] w40, e;
    start_pkt();
    push_sym(30, 48);
    t = 0;
    w40 = exp_word(30, 40, pn[0]);
    while (!(STB_O === 1'b1 && DAT_O === w40) && t < 300) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 300) begin n_bad++; $display("FAIL rstmid_trigger got=timeout want=k40"); end
    RST_I = 1'b1;
    tick();
    @(negedge CLK_I);
    n_cmp += 2;
    if (STB_O !== 1'b0) begin n_bad++; $display("FAIL rstmid_stb got=%b want=0", STB_O); end
    if (CYC_O !== 1'b0) begin n_bad++; $display("FAIL rstmid_cyc got=%b want=0", CYC_O); end
    tick();
    RST_I = 1'b0;
    tick();
    @(negedge CLK_I);
    n_cmp++;
    if (STB_O !== 1'b0) begin n_bad++; $display("FAIL rstmid_after got=%b want=0", STB_O); end
    tick();
    start_pkt();
    push_sym(31, 48);
    CYC_I = 1'b0;
    wait_words(64, 300, "rstmid");
    for (int k = 0; k < 64; k++) begin
      e = exp_word(31, k, pn[0]);
      n_cmp++;
      if (out_q[k] !== e) begin n_bad++; $display("FAIL rstmid_word k=%0d got=%h want=%h", k, out_q[k], e); end
    end
  endtask

  initial begin
    bit sq[134];
    int j;
    // Logical data order over carriers, skipping DC and the four pilots.
    j = 0;
    for (int c = -26; c <= 26; c++) begin
      idx_of_car[c + 26] = 0;
      if (c != 0 && c != 7 && c != -7 && c != 21 && c != -21) begin
        idx_of_car[c + 26] = j;
        j++;
      end
    end
    // Polarity bits by recurrence s[n] = s[n-7] ^ s[n-4], seven ones first.
    for (int i = 0; i < 7; i++) sq[i] = 1'b1;
    for (int i = 7; i < 134; i++) sq[i] = sq[i-7] ^ sq[i-4];
    for (int m = 0; m < 127; m++) pn[m] = sq[m + 7];

    test_reset();
    test_one_symbol();
    test_back_to_back();
    test_partial();
    test_stall();
    test_wrap();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
